// File: rtl/reporte_tx.sv
`default_nettype none
// ============================================================================
// Module      : reporte_tx
// Description : UART 8N1 status reporter; sends A5, humedad[11:8], humedad[7:0],
//               flags. Define REPORTE_CHECKSUM_EN to append an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module reporte_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enviar,
    input  logic [11:0] humedad,
    input  logic        regar,
    input  logic        MODbomba,
    input  logic        MODgrifo,
    input  logic        MODluz,
    output logic        tx,
    output logic        ocupado,
    output logic        hecho
);

    localparam int c_DIV = CLK_HZ / BAUD;
    localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(c_DIV - 1);

`ifdef REPORTE_CHECKSUM_EN
    localparam logic [2:0] c_LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] c_LAST_BYTE = 3'd3;
`endif

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_byte_idx;
    logic [7:0]      r_shift;
    logic [11:0]     r_hum;
    logic [3:0]      r_flags;
    logic            r_tx;
    logic            r_hecho;
    logic [7:0]      w_byte;
    logic            w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_MAX);

    // Byte selected for the next START->DATA load, built from the captured snapshot
    always_comb begin
        w_byte = 8'hA5;
        case (r_byte_idx)
            3'd1:    w_byte = {4'b0000, r_hum[11:8]};
            3'd2:    w_byte = r_hum[7:0];
            3'd3:    w_byte = {4'b0000, r_flags};
`ifdef REPORTE_CHECKSUM_EN
            3'd4:    w_byte = {4'b0000, r_hum[11:8]} ^ r_hum[7:0] ^ {4'b0000, r_flags};
`endif
            default: w_byte = 8'hA5;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_shift    <= 8'h00;
            r_hum      <= 12'h000;
            r_flags    <= 4'h0;
            r_tx       <= 1'b1;
            r_hecho    <= 1'b0;
        end else begin
            r_hecho <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (enviar) begin
                        r_hum      <= humedad;
                        r_flags    <= {regar, MODluz, MODgrifo, MODbomba};
                        r_byte_idx <= 3'd0;
                        r_bit_idx  <= 3'd0;
                        r_cnt      <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= w_byte;
                        r_tx      <= w_byte[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_tx    <= 1'b1;
                            r_hecho <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= c_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign hecho   = r_hecho;
    // Stays high through the hecho cycle even though the FSM is already idle
    assign ocupado = (r_state != c_IDLE) | r_hecho;

endmodule
`default_nettype wire

// File: tb/tb_reporte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_reporte_tx
// Description : Scoreboard bench for reporte_tx at DIV=16 (CLK_HZ=16, BAUD=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reporte_tx;

    localparam int DIV = 16;
`ifdef REPORTE_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME = NB * 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enviar = 1'b0;
    logic [11:0] humedad = 12'h000;
    logic        regar = 1'b0;
    logic        MODbomba = 1'b0;
    logic        MODgrifo = 1'b0;
    logic        MODluz = 1'b0;
    logic        tx;
    logic        ocupado;
    logic        hecho;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         hq[$];
    int         sq[$];
    int         busy_bad;
    int         frame_err;

    reporte_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .enviar(enviar), .humedad(humedad), .regar(regar),
        .MODbomba(MODbomba), .MODgrifo(MODgrifo), .MODluz(MODluz),
        .tx(tx), .ocupado(ocupado), .hecho(hecho)
    );

    always #5 clk = ~clk;

    task automatic push_expected();
        logic [7:0] b1, b2, b3;
        b1 = {4'h0, humedad[11:8]};
        b2 = humedad[7:0];
        b3 = {4'h0, regar, MODluz, MODgrifo, MODbomba};
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
`ifdef REPORTE_CHECKSUM_EN
        exp_q.push_back(b1 ^ b2 ^ b3);
`endif
    endtask

    task automatic pulse_enviar(input bit hold);
        @(negedge clk);
        enviar = 1'b1;
        @(negedge clk);
        if (!hold) enviar = 1'b0;
    endtask

    // Observes n cycles starting at cycle 1 after acceptance, decoding UART bytes into rx_q
    task automatic capture(input int n, input int busy_until, input int mod_cyc,
                           input int poke_cyc, input int drop_cyc);
        int s, k, idx;
        bit inb;
        logic [7:0] sh;
        inb = 0; s = 0; sh = 8'h00;
        busy_bad = 0; frame_err = 0;
        hq.delete(); sq.delete();
        for (int cyc = 1; cyc <= n; cyc++) begin
            if (ocupado !== (cyc <= busy_until)) busy_bad++;
            if (hecho === 1'b1) hq.push_back(cyc);
            if (!inb) begin
                if (tx === 1'b0) begin
                    inb = 1; s = cyc; sq.push_back(cyc);
                end
            end else begin
                k = cyc - s;
                if (k % DIV == DIV / 2) begin
                    idx = k / DIV;
                    if (idx >= 1 && idx <= 8) sh[idx-1] = tx;
                    if (idx == 9) begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(sh);
                        inb = 0;
                    end
                end
            end
            if (cyc == 1 && tx !== 1'b0) frame_err++;
            if (cyc == mod_cyc) humedad = 12'h123;
            if (cyc == poke_cyc) enviar = 1'b1;
            if (cyc == poke_cyc + 1) enviar = 1'b0;
            if (cyc == drop_cyc) enviar = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        n_cmp++; if (hecho !== 1'b0) begin n_fail++; $display("FAIL reset_hecho: got %b want 0", hecho); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: tx=%b ocupado=%b want 1/0", tx, ocupado);
        end
    endtask

    task automatic test_basic();
        logic [7:0] g, e;
        humedad = 12'hABC; regar = 1'b1; MODluz = 1'b0; MODgrifo = 1'b1; MODbomba = 1'b1;
        push_expected();
        pulse_enviar(0);
        capture(FRAME + 1 + 24, FRAME + 1, -10, -10, -10);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_nbytes: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %02h want %02h", g, e); end
        end
        n_cmp++; if (sq.size() == 0 || sq[0] != 1) begin
            n_fail++; $display("FAIL basic_latency: first start cycle %0d want 1", sq.size() ? sq[0] : -1);
        end
        n_cmp++; if (hq.size() != 1 || hq[0] != FRAME + 1) begin
            n_fail++; $display("FAIL basic_hecho: count %0d first %0d want 1 at %0d",
                               hq.size(), hq.size() ? hq[0] : -1, FRAME + 1);
        end
        n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL basic_ocupado: bad cycles %0d want 0", busy_bad); end
        n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL basic_framing: errors %0d want 0", frame_err); end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_patterns();
        logic [7:0] g, e;
        logic [11:0] hv[3] = '{12'h000, 12'hFFF, 12'h5A3};
        logic [3:0]  fv[3] = '{4'h0, 4'hF, 4'h6};
        for (int p = 0; p < 3; p++) begin
            humedad = hv[p];
            {regar, MODluz, MODgrifo, MODbomba} = fv[p];
            push_expected();
            pulse_enviar(0);
            capture(FRAME + 1 + 8, FRAME + 1, -10, -10, -10);
            n_cmp++; if (rx_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL pattern%0d_nbytes: got %0d want %0d", p, rx_q.size(), exp_q.size());
            end
            while (rx_q.size() > 0 && exp_q.size() > 0) begin
                g = rx_q.pop_front(); e = exp_q.pop_front();
                n_cmp++; if (g !== e) begin n_fail++; $display("FAIL pattern%0d_byte: got %02h want %02h", p, g, e); end
            end
            exp_q.delete(); rx_q.delete();
        end
    endtask

    task automatic test_stability();
        logic [7:0] g, e;
        humedad = 12'hABC; regar = 1'b1; MODluz = 1'b0; MODgrifo = 1'b1; MODbomba = 1'b1;
        push_expected();
        pulse_enviar(0);
        capture(FRAME + 1 + 8, FRAME + 1, 170, -10, -10);
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL stability_byte: got %02h want %02h", g, e); end
        end
        n_cmp++; if (exp_q.size() != 0 || rx_q.size() != 0) begin
            n_fail++; $display("FAIL stability_nbytes: leftover exp %0d rx %0d want 0/0", exp_q.size(), rx_q.size());
        end
        exp_q.delete(); rx_q.delete();
        humedad = 12'hABC;
    endtask

    task automatic test_busy_reject();
        logic [7:0] g, e;
        push_expected();
        pulse_enviar(0);
        capture(2 * FRAME + 40, FRAME + 1, -10, 350, -10);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL busy_nbytes: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL busy_byte: got %02h want %02h", g, e); end
        end
        n_cmp++; if (hq.size() != 1) begin n_fail++; $display("FAIL busy_hecho_count: got %0d want 1", hq.size()); end
        n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL busy_ocupado: bad cycles %0d want 0", busy_bad); end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] g, e;
        pulse_enviar(0);
        capture(229, 229, -10, -10, -10);
        n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            n_fail++; $display("FAIL rstmid_b0: got %0d bytes first %02h want 1 byte A5",
                               rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
        end
        rx_q.delete();
        rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        n_cmp++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL rstmid_ocupado: got %b want 0", ocupado); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture(FRAME + 40, 0, -10, -10, -10);
        n_cmp++; if (hq.size() != 0 || rx_q.size() != 0) begin
            n_fail++; $display("FAIL rstmid_quiet: hecho %0d bytes %0d want 0/0", hq.size(), rx_q.size());
        end
        rx_q.delete();
        push_expected();
        pulse_enviar(0);
        capture(FRAME + 1 + 8, FRAME + 1, -10, -10, -10);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_nbytes: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rstmid_byte: got %02h want %02h", g, e); end
        end
        n_cmp++; if (hq.size() != 1 || hq[0] != FRAME + 1) begin
            n_fail++; $display("FAIL rstmid_hecho: count %0d want 1 at %0d", hq.size(), FRAME + 1);
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] g, e;
        humedad = 12'hABC; regar = 1'b1; MODluz = 1'b0; MODgrifo = 1'b1; MODbomba = 1'b1;
        push_expected();
        push_expected();
        pulse_enviar(1);
        capture(2 * (FRAME + 1) + 24, 2 * (FRAME + 1), -10, -10, FRAME + 2);
        enviar = 1'b0;
        n_cmp++; if (rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_nbytes: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            g = rx_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %02h want %02h", g, e); end
        end
        n_cmp++; if (sq.size() <= NB || sq[NB] != FRAME + 2) begin
            n_fail++; $display("FAIL b2b_gap: second frame start %0d want %0d", sq.size() > NB ? sq[NB] : -1, FRAME + 2);
        end
        n_cmp++; if (hq.size() != 2 || hq[0] != FRAME + 1 || hq[1] != 2 * FRAME + 2) begin
            n_fail++; $display("FAIL b2b_hecho: count %0d want 2 at %0d,%0d", hq.size(), FRAME + 1, 2 * FRAME + 2);
        end
        n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL b2b_ocupado: bad cycles %0d want 0", busy_bad); end
        exp_q.delete(); rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_stability();
        test_busy_reject();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
